fifo_rd_stream: RTL
===================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of FIFO read data and stream data.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of delivered-beat counter.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port EMPTY  input  1  FIFO read-side empty flag.
REQ-006 SHALL have port REN  output  1  FIFO read enable.
REQ-007 SHALL have port R_DATA  input  DATA_WIDTH  FIFO read data, valid the cycle after REN.
REQ-008 SHALL have port M_VALID  output  1  stream data valid.
REQ-009 SHALL have port M_READY  input  1  stream sink ready.
REQ-010 SHALL have port M_DATA  output  DATA_WIDTH  stream data.
REQ-011 SHALL have port FLUSH  input  1  single-cycle request to discard all queued data.
REQ-012 SHALL have port FLUSH_DONE  output  1  single-cycle pulse when a flush completes.
REQ-013 SHALL have port BEAT_CNT  output  CNT_WIDTH  count of delivered beats.

Function
REQ-014 SHALL treat REN asserted in cycle n as returning data on R_DATA, sampled at the end of cycle n+1 (one in-flight read).
REQ-015 SHALL hold returned words in a 2-entry in-order buffer; M_VALID = (occupancy > 0), M_DATA = oldest entry, both driven from registers.
REQ-016 SHALL define a beat as M_VALID && M_READY in the same cycle; the head entry pops on a beat.
REQ-017 SHALL hold M_DATA stable while M_VALID && !M_READY.
REQ-018 SHALL assert REN only when !EMPTY && (occupancy + in_flight - beat) < 2; REN SHALL never assert while EMPTY.
REQ-019 SHALL sustain one beat per cycle with M_READY held high and the FIFO non-empty; first M_VALID arrives 2 cycles after first REN.
REQ-020 SHALL never overflow the buffer: a word returning while occupancy is 2 is a design error and never occurs under REQ-018.
REQ-021 SHALL implement states STREAM and FLUSH; reset state STREAM.
REQ-022 STREAM -> FLUSH on FLUSH=1; on entry, clear buffer occupancy, mark any in-flight word for discard, and clear BEAT_CNT.
REQ-023 In FLUSH, SHALL hold M_VALID=0 and assert REN whenever !EMPTY; returned words are discarded.
REQ-024 FLUSH -> STREAM when EMPTY && no in-flight read; FLUSH_DONE SHALL pulse high for exactly that transition cycle.
REQ-025 SHALL ignore FLUSH while already in FLUSH.
REQ-026 BEAT_CNT SHALL increment by 1 per beat and wrap from 2^CNT_WIDTH-1 to 0.
REQ-027 A beat and FLUSH in the same cycle SHALL let the beat complete, but BEAT_CNT SHALL read 0 the next cycle.

Reset
REQ-028 On RST_N=0, SHALL asynchronously set state=STREAM, occupancy=0, in_flight=0, REN=0, M_VALID=0, M_DATA=0, FLUSH_DONE=0, BEAT_CNT=0.
REQ-029 SHALL discard any read outstanding when reset asserts mid-operation; the first REN after release SHALL occur no earlier than the first cycle after RST_N rises.

Structure
REQ-030 SHALL take the state enum typedef (STREAM, FLUSH) from shared package fifo_pkg.
REQ-031 SHALL implement the 2-entry buffer as sub-module fifo_skid_buf (push, pop, data, occupancy).

Verification
REQ-032 Reset release, EMPTY=1 throughout -> REN=0, M_VALID=0, BEAT_CNT=0 for 20 cycles.
REQ-033 FIFO preloaded with 0x01..0x08, M_READY=1 -> M_DATA 0x01..0x08 on 8 consecutive cycles, BEAT_CNT=8.
REQ-034 Same preload, M_READY toggled 1,0,0,1 repeating -> order 0x01..0x08 preserved, M_DATA stable while stalled, REN never asserts with 2 entries buffered and no pop.
REQ-035 FLUSH pulsed with 2 words buffered and 5 words in FIFO -> M_VALID=0 next cycle, FIFO drained, single FLUSH_DONE, BEAT_CNT=0.
REQ-036 CNT_WIDTH=4, 17 beats -> BEAT_CNT wraps 15 -> 0 and reads 1.
REQ-037 RST_N asserted 1 cycle after REN -> outputs at reset values immediately; stale R_DATA never appears on M_DATA.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side streaming logic.
//   rd_state_e    : controller states (stream data out / flush queued data)
//   BUF_DEPTH     : depth of the output buffer between FIFO and stream
//   room_for_read : headroom test used to decide whether a new read may issue
package fifo_pkg;

  // ST_STREAM is the STREAM state, ST_FLUSH is the FLUSH state.
  typedef enum logic [0:0] {
    ST_STREAM = 1'b0,
    ST_FLUSH  = 1'b1
  } rd_state_e;

  localparam int unsigned BUF_DEPTH = 2;

  // True when (occ + in_flight - beat) < BUF_DEPTH, rewritten without
  // subtraction so no underflow can occur.
  function automatic logic room_for_read(input logic [1:0] occ,
                                         input logic       in_flight,
                                         input logic       beat);
    logic [2:0] committed;
    logic [2:0] limit;
    committed = {1'b0, occ} + {2'b00, in_flight};
    limit     = 3'(BUF_DEPTH) + {2'b00, beat};
    return (committed < limit);
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order buffer holding words returned from the FIFO.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : drop all entries (takes priority over push)
//   push        : write push_data behind the current entries
//   push_data   : word to write
//   pop         : remove the head entry (ignored when empty)
//   head_data   : oldest entry, registered
//   valid       : buffer non-empty, registered
//   occupancy   : number of entries held (0..2)
module fifo_skid_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  valid,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] tail_r;
  logic [1:0]            occ_r;
  logic                  valid_r;

  logic [DATA_WIDTH-1:0] head_nxt_s;
  logic [DATA_WIDTH-1:0] tail_nxt_s;
  logic [1:0]            occ_nxt_s;
  logic                  pop_s;

  assign pop_s     = pop && (occ_r != 2'd0);
  assign head_data = head_r;
  assign valid     = valid_r;
  assign occupancy = occ_r;

  // Next-state of the entries and occupancy for push / pop / clear.
  always_comb begin
    head_nxt_s = head_r;
    tail_nxt_s = tail_r;
    occ_nxt_s  = occ_r;
    if (clr) begin
      occ_nxt_s = 2'd0;
    end else begin
      case ({push, pop_s})
        2'b10: begin
          case (occ_r)
            2'd0: begin
              head_nxt_s = push_data;
              occ_nxt_s  = 2'd1;
            end
            2'd1: begin
              tail_nxt_s = push_data;
              occ_nxt_s  = 2'd2;
            end
            // Push into a full buffer cannot happen under the read
            // headroom rule; the word is dropped rather than corrupting order.
            default: begin
              occ_nxt_s = occ_r;
            end
          endcase
        end
        2'b01: begin
          if (occ_r == 2'd2) begin
            head_nxt_s = tail_r;
          end else begin
            head_nxt_s = head_r;
          end
          occ_nxt_s = occ_r - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind the survivor.
          if (occ_r == 2'd1) begin
            head_nxt_s = push_data;
          end else begin
            head_nxt_s = tail_r;
            tail_nxt_s = push_data;
          end
        end
        default: begin
          occ_nxt_s = occ_r;
        end
      endcase
    end
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {DATA_WIDTH{1'b0}};
      tail_r  <= {DATA_WIDTH{1'b0}};
      occ_r   <= 2'd0;
      valid_r <= 1'b0;
    end else begin
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      occ_r   <= occ_nxt_s;
      valid_r <= (occ_nxt_s != 2'd0);
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Converts a FIFO read port (read enable, data one cycle later) into a
// valid/ready stream, with a flush that discards all queued data.
// Ports:
//   CLK, RST_N  : clock, asynchronous active-low reset
//   EMPTY       : FIFO empty flag
//   REN         : FIFO read enable
//   R_DATA      : FIFO read data, valid the cycle after REN
//   M_VALID     : stream valid (registered)
//   M_READY     : stream sink ready
//   M_DATA      : stream data (registered)
//   FLUSH       : single-cycle flush request
//   FLUSH_DONE  : single-cycle pulse when the flush has finished
//   BEAT_CNT    : delivered-beat counter, wraps
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EMPTY,
  output logic                  REN,
  input  logic [DATA_WIDTH-1:0] R_DATA,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [DATA_WIDTH-1:0] M_DATA,
  input  logic                  FLUSH,
  output logic                  FLUSH_DONE,
  output logic [CNT_WIDTH-1:0]  BEAT_CNT
);
  import fifo_pkg::*;

  rd_state_e             state_r;
  rd_state_e             state_nxt_s;
  logic                  run_r;
  logic                  in_flight_r;
  logic                  flush_done_r;
  logic [CNT_WIDTH-1:0]  beat_cnt_r;

  logic                  ren_s;
  logic                  push_s;
  logic                  beat_s;
  logic                  flush_start_s;
  logic                  flush_exit_s;
  logic [1:0]            occ_s;
  logic                  valid_s;
  logic [DATA_WIDTH-1:0] head_s;

  assign beat_s = valid_s && M_READY;

  // REN has to follow EMPTY within the same cycle, so it is the one output
  // that cannot come straight from a flop; run_r keeps it low through reset
  // and the first cycle after release.
  assign REN        = ren_s;
  assign M_VALID    = valid_s;
  assign M_DATA     = head_s;
  assign FLUSH_DONE = flush_done_r;
  assign BEAT_CNT   = beat_cnt_r;

  // Next state, read enable and buffer push decisions.
  always_comb begin
    state_nxt_s   = state_r;
    ren_s         = 1'b0;
    push_s        = 1'b0;
    flush_start_s = 1'b0;
    flush_exit_s  = 1'b0;
    case (state_r)
      ST_STREAM: begin
        ren_s = run_r && !EMPTY && room_for_read(occ_s, in_flight_r, beat_s);
        if (FLUSH) begin
          // The word landing at this edge and any read issued now are
          // dropped: no push here, and FLUSH never pushes.
          state_nxt_s   = ST_FLUSH;
          flush_start_s = 1'b1;
        end else begin
          push_s = in_flight_r;
        end
      end
      ST_FLUSH: begin
        ren_s = run_r && !EMPTY;
        if (EMPTY && !in_flight_r) begin
          state_nxt_s  = ST_STREAM;
          flush_exit_s = 1'b1;
        end else begin
          state_nxt_s = ST_FLUSH;
        end
      end
      default: begin
        state_nxt_s = ST_STREAM;
      end
    endcase
  end

  // Controller state, read tracking, flush pulse and beat counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r      <= ST_STREAM;
      run_r        <= 1'b0;
      in_flight_r  <= 1'b0;
      flush_done_r <= 1'b0;
      beat_cnt_r   <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      run_r        <= 1'b1;
      in_flight_r  <= ren_s;
      flush_done_r <= flush_exit_s;
      if (flush_start_s) begin
        beat_cnt_r <= {CNT_WIDTH{1'b0}};
      end else if (beat_s) begin
        beat_cnt_r <= beat_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
    end
  end

  fifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk       (CLK),
    .rst_n     (RST_N),
    .clr       (flush_start_s),
    .push      (push_s),
    .push_data (R_DATA),
    .pop       (beat_s),
    .head_data (head_s),
    .valid     (valid_s),
    .occupancy (occ_s)
  );

endmodule
